// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack
//   Result stage of the iterative FP add/sub/mul datapath. It captures the raw
//   sign, exponent and extended mantissa, then normalises one bit per cycle.
//   It rounds to nearest-even, resolves NaN/Inf/zero/overflow/underflow, and
//   packs an IEEE-754 single. The packed result is held on a valid/ready
//   handshake.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   operand handshake; in_ready is high only in IDLE
//   in_sign/exp/mant raw result; mant = {carry, hidden, frac[22:0], g, r, s}
//   in_nan/in_inf    special-result markers from the datapath
//   out_valid/ready  result handshake; outputs are held until accepted
//   out_result       packed single-precision result
//   out_overflow     result saturated to infinity
//   out_underflow    nonzero result flushed to zero
module fp_normalize_pack #(
  parameter int          EXP_W     = 10,
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [27:0]             in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_overflow,
  output logic                    out_underflow
);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;

  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [27:0]             mant_q, mant_d;
  logic                    nan_q, nan_d, inf_q, inf_d;
  logic                    valid_q, valid_d;
  logic [31:0]             res_q, res_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;
  logic                    rnd_up;
  logic [27:0]             mant_rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    valid_d  = valid_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    // Round-to-nearest-even: round up on guard, unless it is an exact tie
    // and the lsb is already even.
    rnd_up   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    mant_rnd = rnd_up ? mant_q + 28'd8 : mant_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          nan_d   = in_nan;
          inf_d   = in_inf;
          state_d = NORM;
        end
      end
      NORM: begin
        if (nan_q || inf_q || (mant_q == '0)) begin
          state_d = ROUND;
        end else if (mant_q[27]) begin
          // Fold the bit shifted out into sticky so rounding still sees it.
          mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + EXP_ONE;
        end else if (!mant_q[26]) begin
          mant_d = {mant_q[26:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        // A round-up that ripples into the carry bit renormalises here.
        if (mant_rnd[27]) begin
          mant_d = {1'b0, mant_rnd[27:2], mant_rnd[1] | mant_rnd[0]};
          exp_d  = exp_q + EXP_ONE;
        end else begin
          mant_d = mant_rnd;
        end
        state_d = PACK;
      end
      PACK: begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (nan_q)                res_d = NAN_VALUE;
        else if (inf_q)           res_d = {sign_q, 8'hFF, 23'b0};
        else if (mant_q == '0)    res_d = {sign_q, 31'b0};
        else if (exp_q >= EXP_MAX) begin
          res_d = {sign_q, 8'hFF, 23'b0};
          ovf_d = 1'b1;
        end else if (exp_q <= EXP_ZERO) begin
          res_d = {sign_q, 31'b0};
          unf_d = 1'b1;
        end else                  res_d = {sign_q, exp_q[7:0], mant_q[25:3]};
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = valid_q;
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
- Downstream result stage of the iterative FP DSP datapath (add/sub/mul).
- When the control FSM signals a finished operation, it takes the raw sign, exponent and extended mantissa from the DSP48E1 P output.
- It normalises iteratively (one bit per cycle), rounds to nearest-even, handles overflow/underflow/special cases and packs an IEEE-754 single.
- Result is held on a valid/ready output handshake.

Parameters:
EXP_W, 10, signed two's-complement width of the internal biased exponent (bias 127).
NAN_VALUE, 32'h7FC00000, canonical quiet NaN emitted for NaN results.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation result available (driven from control ready)
in_ready  out  1  block can accept; high only in IDLE
in_sign  in  1  result sign
in_exp  in  EXP_W  signed biased exponent, pre-normalisation; producer guarantees -100..400
in_mant  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
in_nan  in  1  special: result is NaN
in_inf  in  1  special: result is infinity
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_result  out  32  packed single-precision result
out_overflow  out  1  result saturated to infinity by overflow
out_underflow  out  1  nonzero result flushed to zero

Behaviour:
- Reset: state IDLE; out_valid=0, out_result=0, out_overflow=0, out_underflow=0, in_ready=1; internal mant/exp/sign cleared.
- Reset in any state, including mid-NORM or DONE, aborts the operation and discards the result. Next cycle is IDLE with out_valid=0.

FSM:
- IDLE: on in_valid, capture sign, exp, mant, nan and inf, then go to NORM. in_valid is ignored in every other state, since in_ready=0.
- NORM: one action per cycle.
  - If nan or inf is set, or mant==0: go to ROUND, no shift.
  - Else if mant[27]=1: shift right 1, new bit0 = old bit1 | old bit0 (sticky preserved), exp+1, stay.
  - Else if mant[26]=0: shift left 1 (zero fill), exp-1, stay.
  - Else (normalised): go to ROUND.
- ROUND (1 cycle): lsb=mant[3], g=mant[2], rs=mant[1]|mant[0].
  - If g & (rs | lsb), add 8 to mant.
  - If that sets mant[27], shift right 1 and exp+1 in the same cycle.
- PACK (1 cycle): register out_result and flags, set out_valid, go to DONE. Priority:
  1. nan: NAN_VALUE, flags 0.
  2. inf: {sign, 8'hFF, 23'b0}, flags 0.
  3. mant==0: {sign, 31'b0}, flags 0.
  4. exp>=255: {sign, 8'hFF, 23'b0}, out_overflow=1.
  5. exp<=0: {sign, 31'b0}, out_underflow=1 (denormals not supported).
  6. Otherwise: {sign, exp[7:0], mant[25:3]}.
- DONE: hold all outputs stable while out_ready=0. On out_ready=1: out_valid=0 and flags cleared next edge, out_result retained, go to IDLE. An in_valid in the DONE cycle is not accepted.

Timing:
- Latency: accept edge E0; out_valid rises at edge E(3+n), where n is the number of NORM shifts.
- Maximum n is 26, for a single set bit at [0] or one right shift. Minimum latency is 3 edges.
- Exponent arithmetic is EXP_W-bit signed; given the input range, no wrap is possible.

Test Plan:
- Normalised 1.0: in_mant=28'h4000000, in_exp=127, sign 0 -> out_result=32'h3F800000; out_valid at E3; flags 0.
- Carry: in_mant=28'h8000000, in_exp=127 -> 32'h40000000 at E4. Left shift: in_mant=28'h0000008, in_exp=150 -> 23 shifts, 32'h3F800000 at E26.
- Rounding:
  - in_mant=28'h4000004 (tie, lsb 0), exp 127 -> 32'h3F800000.
  - in_mant=28'h400000C (tie, lsb 1) -> 32'h3F800002.
  - in_mant=28'h4000006 (g=1, r=1) -> 32'h3F800001.
- Round overflow: in_mant=28'h7FFFFFC, in_exp=254 -> rounding carry, exp 255 -> 32'h7F800000, out_overflow=1. Underflow: in_mant=28'h4000000, in_exp=0 -> 32'h00000000, out_underflow=1.
- Specials and zero:
  - in_nan=1 -> 32'h7FC00000.
  - in_inf=1, sign 1 -> 32'hFF800000.
  - in_mant=0, sign 1 -> 32'h80000000 at E3, no flags.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles -> result and out_valid stable; in_ready=0; a second in_valid is ignored.
  - out_ready=1 -> IDLE next edge.
  - rst asserted during NORM of the 23-shift case -> IDLE, out_valid=0. A following 1.0 input returns 32'h3F800000.
